sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO for buffering byte/word streams between RFID baseband stages, e.g. decoder output to command parser.
- Generalises the existing 8x8 FIFO:
  - configurable width, depth and almost-full/almost-empty thresholds;
  - occupancy count output;
  - registered read data with a valid strobe;
  - synchronous flush;
  - sticky overflow/underflow error flags.

---
 rtl/sync_fifo_param.sv | 95 +++++++++
 tb/tb_sync_fifo_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               flush,
  input  logic               write,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               read,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic [$clog2(DEPTH):0] level,
  output logic               overflow,
  output logic               underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  // Request/accept semantics: a request is consumed only in a cycle where it
  // is accepted (wr_acc/rd_acc); rejected requests are dropped and flagged.
  // An accepted read presents its word on data_out with data_valid one clock later.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             go;
  logic             rd_acc;
  logic             wr_acc;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level        = wr_ptr - rd_ptr;
  assign almost_empty = (level <= AEMPTY_LVL);
  assign almost_full  = (level >= AFULL_LVL);

  // A read frees a slot in the same edge, so a full FIFO still takes a write
  // alongside a read; there is no bypass into an empty FIFO.
  assign go     = en & ~flush;
  assign rd_acc = go & read & ~empty;
  assign wr_acc = go & write & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (!en) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (write && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (read && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model,
// expected-read scoreboard drained by a negedge monitor, directed plus random stimulus.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             flush;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [3:0]       level;
  logic             overflow;
  logic             underflow;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
    .write(write), .data_in(data_in), .read(read),
    .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  // reference model: contents as a queue, plus sticky flags
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf;
  logic             m_unf;
  logic             m_dv;
  int               vectors;
  int               miscompares;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_dv  = 1'b0;
  endtask

  // driver: apply one cycle of stimulus, then advance the model by the same edge
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic f = 1'b0, input logic e = 1'b1);
    logic rd_ok;
    logic wr_ok;
    write   = w;
    data_in = d;
    read    = r;
    flush   = f;
    en      = e;
    @(posedge clk);
    if (f) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_dv  = 1'b0;
    end else if (!e) begin
      m_dv = 1'b0;
    end else begin
      rd_ok = r && (model_q.size() > 0);
      wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
      if (r && !rd_ok) m_unf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) exp_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(d);
      m_dv = rd_ok;
    end
    #1;
  endtask

  task automatic idle_inputs();
    write   = 1'b0;
    read    = 1'b0;
    flush   = 1'b0;
    en      = 1'b1;
    data_in = '0;
  endtask

  // monitor: status flags against the model, read data against the scoreboard
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    chk("level", 32'(level), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
    chk("almost_full", 32'(almost_full), 32'(n >= AF_TH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    if (m_dv || data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(data_valid), 32'(0));
      end else begin
        chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset values
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_aempty", 32'(almost_empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_dout", 32'(data_out), 32'(0));
    chk("rst_dv", 32'(data_valid), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_unf", 32'(underflow), 32'(0));

    // fill 0x11..0x18, then overflow
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h11 + i), 1'b0);
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 6));
    end
    chk("fill_full", 32'(full), 32'(1));
    step(1'b1, 8'h99, 1'b0);
    chk("ovf_set", 32'(overflow), 32'(1));
    chk("ovf_level", 32'(level), 32'(8));

    // drain in order, then underflow
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_dout", 32'(data_out), 32'(8'h11 + i));
      chk("drain_dv", 32'(data_valid), 32'(1));
    end
    chk("drain_empty", 32'(empty), 32'(1));
    step(1'b0, 8'h00, 1'b1);
    chk("unf_set", 32'(underflow), 32'(1));
    chk("unf_dv", 32'(data_valid), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // wrap-around at steady level 4
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 4; i < 20; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b1);
      chk("wrap_level", 32'(level), 32'(4));
      chk("wrap_dout", 32'(data_out), 32'(8'h20 + i - 4));
    end
    chk("wrap_flags", 32'({overflow, underflow}), 32'(0));
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // simultaneous read/write while full, then while empty
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    chk("full_rw_level", 32'(level), 32'(8));
    chk("full_rw_ovf", 32'(overflow), 32'(0));
    chk("full_rw_dout", 32'(data_out), 32'(8'h40));
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hAA, 1'b1);
    chk("empty_rw_level", 32'(level), 32'(1));
    chk("empty_rw_unf", 32'(underflow), 32'(1));
    step(1'b0, 8'h00, 1'b1);
    chk("empty_rw_dout", 32'(data_out), 32'(8'hAA));

    // flush at level 5 with overflow set and a concurrent write
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("pre_flush_level", 32'(level), 32'(5));
    chk("pre_flush_ovf", 32'(overflow), 32'(1));
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("flush_level", 32'(level), 32'(0));
    chk("flush_empty", 32'(empty), 32'(1));
    chk("flush_ovf", 32'(overflow), 32'(0));
    chk("flush_dout_hold", 32'(data_out), 32'(8'h52));

    // en low ignores requests
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("en_level", 32'(level), 32'(0));
    chk("en_flags", 32'({overflow, underflow}), 32'(0));

    // asynchronous reset mid-burst, away from any clock edge
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b1, 8'h73, 1'b1);
    #2 reset_n = 1'b0;
    model_reset();
    idle_inputs();
    #1;
    chk("arst_level", 32'(level), 32'(0));
    chk("arst_empty", 32'(empty), 32'(1));
    chk("arst_dout", 32'(data_out), 32'(0));
    chk("arst_dv", 32'(data_valid), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 92));
    end
    idle_inputs();
    repeat (3) step(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
